// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, opcodes and the decoded issue record
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_NOR = 4'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       use_imm;
        logic       is_branch;
        logic       illegal;
    } alu_issue_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational map from an RV64 instruction word to ALU issue fields
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_issue_t  issue
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign f7          = instr[31:25];
    // Register and immediate fields do not affect the ALU control code.
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // Decode the supported subset; everything else is flagged illegal with zeroed fields.
    always_comb begin
        issue = '{alu_ctrl: ALU_AND, use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b1};
        case (opcode)
            OP_LOAD, OP_STORE: begin
                if (f3 == 3'b011) begin
                    issue = '{alu_ctrl: ALU_ADD, use_imm: 1'b1, is_branch: 1'b0, illegal: 1'b0};
                end
            end
            OP_BRANCH: begin
                if (f3 == 3'b000) begin
                    issue = '{alu_ctrl: ALU_SUB, use_imm: 1'b0, is_branch: 1'b1, illegal: 1'b0};
                end
            end
            OP_RTYPE: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: issue = '{alu_ctrl: ALU_ADD, use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b0};
                        3'b111: issue = '{alu_ctrl: ALU_AND, use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b0};
                        3'b110: issue = '{alu_ctrl: ALU_OR,  use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b0};
                        default: ;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    issue = '{alu_ctrl: ALU_SUB, use_imm: 1'b0, is_branch: 1'b0, illegal: 1'b0};
                end
            end
            OP_ITYPE: begin
                case (f3)
                    3'b000: issue = '{alu_ctrl: ALU_ADD, use_imm: 1'b1, is_branch: 1'b0, illegal: 1'b0};
                    3'b111: issue = '{alu_ctrl: ALU_AND, use_imm: 1'b1, is_branch: 1'b0, illegal: 1'b0};
                    3'b110: issue = '{alu_ctrl: ALU_OR,  use_imm: 1'b1, is_branch: 1'b0, illegal: 1'b0};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - instruction decode into a 2-entry skid buffer feeding the ALU
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_ctrl,
    output logic             out_use_imm,
    output logic             out_is_branch,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    alu_issue_t dec;
    alu_issue_t head;
    alu_issue_t tail;
    logic [1:0] occ;
    logic       push;
    logic       pop;

    alu_ctrl_decode u_decode (
        .instr (in_instr),
        .issue (dec)
    );

    // Ready depends only on registered occupancy, so no ready path runs back from the consumer.
    assign in_ready = !rst && (occ != 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign out_valid     = (occ != 2'd0);
    assign out_alu_ctrl  = head.alu_ctrl;
    assign out_use_imm   = head.use_imm;
    assign out_is_branch = head.is_branch;
    assign out_illegal   = head.illegal;

    // Two-slot FIFO: head drives the outputs, tail absorbs one op while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head <= dec;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= dec;
                    end else if (push) begin
                        tail <= dec;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Count accepted illegal ops, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (push && dec.illegal && !(&illegal_count)) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb/tb_alu_ctrl_issue.sv - randomized and directed self-checking bench for alu_ctrl_issue
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_ctrl;
    logic        out_use_imm;
    logic        out_is_branch;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    alu_ctrl_issue #(.CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_ctrl  (out_alu_ctrl),
        .out_use_imm   (out_use_imm),
        .out_is_branch (out_is_branch),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] q[$];
    int         cnt_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {ctrl[3:0], use_imm, is_branch, illegal}.
    function automatic logic [6:0] ref_decode(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if ((op == 7'h03 || op == 7'h23) && f3 == 3'd3) return {4'd2, 3'b100};
        if (op == 7'h63 && f3 == 3'd0)                  return {4'd6, 3'b010};
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0)   return {4'd2, 3'b000};
        if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0)   return {4'd6, 3'b000};
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7)   return {4'd0, 3'b000};
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6)   return {4'd1, 3'b000};
        if (op == 7'h13 && f3 == 3'd0)                  return {4'd2, 3'b100};
        if (op == 7'h13 && f3 == 3'd7)                  return {4'd0, 3'b100};
        if (op == 7'h13 && f3 == 3'd6)                  return {4'd1, 3'b100};
        return {4'd0, 3'b001};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[5];
        logic [31:0] w;
        int          k;
        int          s;
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h63; ops[3] = 7'h33; ops[4] = 7'h13;
        w = $urandom;
        k = $urandom_range(0, 5);
        if (k < 5) w[6:0] = ops[k];
        w[14:12] = 3'($urandom_range(0, 7));
        s = $urandom_range(0, 3);
        if (s < 2)       w[31:25] = 7'h00;
        else if (s == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    // One clock cycle: drive inputs, check DUT state against the model, advance the model.
    task automatic cycle(input logic r, input logic v, input logic [31:0] w, input logic ordy, input string tag);
        logic       push;
        logic       pop;
        logic [6:0] e;
        rst       = r;
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!r && q.size() < 2));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0)
            check({tag, ".fields"}, 32'({out_alu_ctrl, out_use_imm, out_is_branch, out_illegal}), 32'(q[0]));
        check({tag, ".count"}, 32'(illegal_count), 32'(cnt_m));
        push = v && !r && q.size() < 2;
        pop  = !r && q.size() > 0 && ordy;
        if (r) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e = ref_decode(w);
                q.push_back(e);
                if (e[0] && cnt_m < 255) cnt_m++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] sweep[6];
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, "reset");
        cycle(1'b1, 1'b0, 32'h0, 1'b0, "reset");
        check("reset.fields_zero", 32'({out_alu_ctrl, out_use_imm, out_is_branch, out_illegal}), 32'h0);

        sweep[0] = 32'h003100B3; sweep[1] = 32'h403100B3; sweep[2] = 32'h00013083;
        sweep[3] = 32'h00208063; sweep[4] = 32'h00000000; sweep[5] = 32'h003110B3;
        foreach (sweep[i]) cycle(1'b0, 1'b1, sweep[i], 1'b1, "sweep");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "sweep_drain");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "sweep_idle");

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rand_instr(), 1'b0, "bp_fill");
        cycle(1'b0, 1'b0, 32'h0, 1'b0, "bp_hold");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, "bp_drain");

        cycle(1'b0, 1'b1, rand_instr(), 1'b0, "pp_prime");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, rand_instr(), 1'b1, "pushpop");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "pp_drain");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "pp_idle");

        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 32'h0, 1'b1, "illegal_sat");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "sat_drain");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "sat_idle");

        cycle(1'b0, 1'b1, 32'h003100B3, 1'b0, "rst_fill");
        cycle(1'b0, 1'b1, 32'h00013083, 1'b0, "rst_fill");
        cycle(1'b1, 1'b1, 32'h00208063, 1'b1, "rst_mid");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "post_rst");
        cycle(1'b0, 1'b0, 32'h0, 1'b1, "post_rst");

        for (int i = 0; i < 2000; i++)
            cycle(1'b0 | ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  rand_instr(), ($urandom_range(0, 2) != 0), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
